// File: rtl/mb_pkg.sv
// Shared constants, FSM encoding and helpers for the macroblock assembler.
package mb_pkg;

  localparam int unsigned IN_WIDTH       = 1024;
  localparam int unsigned OUT_WIDTH      = 128;
  localparam int unsigned MB_COORD_WIDTH = 6;

  localparam int unsigned LUMA_BEATS     = 16;
  localparam int unsigned CHROMA_BEATS   = 8;
  localparam int unsigned MB_BEATS       = 24;
  localparam int unsigned MB_PIX         = 16;
  localparam int unsigned BYTES_PER_WORD = 128;
  localparam int unsigned UV_V_OFFSET    = 64;

  localparam int unsigned BUF_WIDTH      = 3 * IN_WIDTH;
  localparam int unsigned BEAT_W         = 5;
  // Holds up to 64 MBs (1023-pixel frame rounds up to 64).
  localparam int unsigned MB_DIM_W       = 7;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StSend,
    StDone
  } mb_state_e;

  // Pixels to macroblocks, rounding up; 11-bit intermediate avoids overflow at 1023.
  function automatic logic [MB_DIM_W-1:0] mb_count(input logic [9:0] pix);
    return MB_DIM_W'(({1'b0, pix} + 11'd15) >> 4);
  endfunction

endpackage

// File: rtl/mb_beat_select.sv
// Picks one 128-bit beat out of the captured {UV, Y1, Y0} buffer by beat index.
module mb_beat_select
  import mb_pkg::*;
(
  input  logic [BUF_WIDTH-1:0] i_buf,
  input  logic [BEAT_W-1:0]    i_beat,
  output logic [OUT_WIDTH-1:0] o_data
);

  logic [11:0] w_luma_lo;
  logic [11:0] w_u_lo;
  logic [11:0] w_v_lo;

  // Y0 and Y1 are adjacent, so luma row b is simply buffer row b. UV word starts at bit 2048,
  // V half at bit 2560; chroma row j = beat[2:0] for beats 16..23.
  always_comb begin
    w_luma_lo = {1'b0, i_beat[3:0], 7'd0};
    w_u_lo    = {3'b100, i_beat[2:0], 6'd0};
    w_v_lo    = {3'b101, i_beat[2:0], 6'd0};
    o_data    = '0;
    if (!i_beat[4]) begin
      o_data = i_buf[w_luma_lo +: OUT_WIDTH];
    end else if (!i_beat[3]) begin
      o_data = {i_buf[w_v_lo +: OUT_WIDTH/2], i_buf[w_u_lo +: OUT_WIDTH/2]};
    end
  end

endmodule

// File: rtl/mb_assembler.sv
// Pops one word from each of the Y0/Y1/UV FIFOs per macroblock and streams it as 24 beats.
// Optional stall counters are built when MB_ASSEMBLER_PERF_EN is defined.
module mb_assembler
  import mb_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_pulse,
  input  logic [9:0]                w1,
  input  logic [9:0]                h1,
  input  logic                      Y0_fifo_empty,
  input  logic                      Y1_fifo_empty,
  input  logic                      UV_fifo_empty,
  input  logic [IN_WIDTH-1:0]       Y0_fifo_dout,
  input  logic [IN_WIDTH-1:0]       Y1_fifo_dout,
  input  logic [IN_WIDTH-1:0]       UV_fifo_dout,
  output logic                      Y0_fifo_rd,
  output logic                      Y1_fifo_rd,
  output logic                      UV_fifo_rd,
  output logic                      mb_valid,
  input  logic                      mb_ready,
  output logic [OUT_WIDTH-1:0]      mb_data,
  output logic                      mb_sop,
  output logic                      mb_eop,
  output logic                      mb_is_chroma,
  output logic [MB_COORD_WIDTH-1:0] mb_x,
  output logic [MB_COORD_WIDTH-1:0] mb_y,
  output logic                      mb_last,
  output logic                      busy,
  output logic                      done
`ifdef MB_ASSEMBLER_PERF_EN
  ,
  output logic [31:0]               stall_in_cnt,
  output logic [31:0]               stall_out_cnt
`endif
);

  mb_state_e                 r_state;
  mb_state_e                 w_state_nxt;
  logic [MB_DIM_W-1:0]       r_mb_w;
  logic [MB_DIM_W-1:0]       r_mb_h;
  logic [MB_COORD_WIDTH-1:0] r_x;
  logic [MB_COORD_WIDTH-1:0] r_y;
  logic [BEAT_W-1:0]         r_beat;
  logic [BUF_WIDTH-1:0]      r_buf;

  logic                      w_all_ne;
  logic                      w_send;
  logic                      w_hs;
  logic                      w_mb_end;
  logic                      w_x_end;
  logic                      w_is_last;
  logic                      w_dim_zero;
  logic                      w_pop;
  logic [OUT_WIDTH-1:0]      w_beat_data;

  assign w_all_ne   = !Y0_fifo_empty && !Y1_fifo_empty && !UV_fifo_empty;
  assign w_send     = (r_state == StSend);
  assign w_hs       = w_send && mb_ready;
  assign w_mb_end   = w_hs && (r_beat == BEAT_W'(MB_BEATS - 1));
  assign w_x_end    = ({1'b0, r_x} == r_mb_w - 7'd1);
  assign w_is_last  = w_x_end && ({1'b0, r_y} == r_mb_h - 7'd1);
  assign w_dim_zero = (mb_count(w1) == '0) || (mb_count(h1) == '0);

  // All three FIFOs pop together; start_pulse wins over any pop in the same cycle.
  assign w_pop = !start_pulse && w_all_ne &&
                 ((r_state == StWait) || (w_mb_end && !w_is_last));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    if (start_pulse) begin
      w_state_nxt = w_dim_zero ? StDone : StWait;
    end else begin
      unique case (r_state)
        StIdle: w_state_nxt = StIdle;
        StWait: if (w_all_ne) w_state_nxt = StSend;
        StSend: begin
          if (w_mb_end) begin
            if (w_is_last)      w_state_nxt = StDone;
            else if (!w_all_ne) w_state_nxt = StWait;
          end
        end
        StDone: w_state_nxt = StIdle;
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    Y0_fifo_rd   = w_pop;
    Y1_fifo_rd   = w_pop;
    UV_fifo_rd   = w_pop;
    mb_valid     = w_send;
    mb_data      = w_send ? w_beat_data : '0;
    mb_sop       = w_send && (r_beat == '0);
    mb_eop       = w_send && (r_beat == BEAT_W'(MB_BEATS - 1));
    mb_is_chroma = w_send && (r_beat >= BEAT_W'(LUMA_BEATS));
    mb_x         = r_x;
    mb_y         = r_y;
    mb_last      = w_send && w_is_last;
    busy         = (r_state == StWait) || w_send;
    done         = (r_state == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mb_w <= '0;
      r_mb_h <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_beat <= '0;
    end else if (start_pulse) begin
      r_mb_w <= mb_count(w1);
      r_mb_h <= mb_count(h1);
      r_x    <= '0;
      r_y    <= '0;
      r_beat <= '0;
    end else begin
      if (w_pop) begin
        r_beat <= '0;
      end else if (w_hs) begin
        r_beat <= w_mb_end ? '0 : r_beat + 5'd1;
      end
      if (w_mb_end) begin
        if (w_x_end) begin
          r_x <= '0;
          r_y <= r_y + 6'd1;
        end else begin
          r_x <= r_x + 6'd1;
        end
      end
    end
  end

  // Payload storage needs no reset: mb_data is gated by mb_valid.
  always_ff @(posedge clk) begin
    if (w_pop) r_buf <= {UV_fifo_dout, Y1_fifo_dout, Y0_fifo_dout};
  end

  mb_beat_select u_beat_select (
    .i_buf  (r_buf),
    .i_beat (r_beat),
    .o_data (w_beat_data)
  );

`ifdef MB_ASSEMBLER_PERF_EN
  logic [31:0] r_stall_in;
  logic [31:0] r_stall_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_in  <= '0;
      r_stall_out <= '0;
    end else if (start_pulse) begin
      r_stall_in  <= '0;
      r_stall_out <= '0;
    end else begin
      if ((r_state == StWait) && !w_all_ne && (r_stall_in != '1)) begin
        r_stall_in <= r_stall_in + 32'd1;
      end
      if (w_send && !mb_ready && (r_stall_out != '1)) begin
        r_stall_out <= r_stall_out + 32'd1;
      end
    end
  end

  assign stall_in_cnt  = r_stall_in;
  assign stall_out_cnt = r_stall_out;
`endif

endmodule

// File: doc/mb_assembler.md
Name: mb_assembler

Overview:
Downstream consumer of the Y0/Y1/UV FIFOs filled by the AXI read master in the WebP encode path. Pops one 1024-bit word from each FIFO per macroblock and streams a 16x16 luma + 8x8 U/V macroblock as 24 beats of 128 bits to the encode core. Beats carry raster MB coordinates and frame framing. Feeds the prediction/transform pipeline.

Parameters:
IN_WIDTH, 1024, FIFO word width; fixed at 128 bytes.
OUT_WIDTH, 128, beat width; one luma row or one U+V row pair.
MB_COORD_WIDTH, 6, MB coordinate width; covers 1023-pixel dimensions.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_pulse  in  1  frame start; latches w1/h1
w1  in  10  frame width, pixels
h1  in  10  frame height, pixels
Y0_fifo_empty / Y1_fifo_empty / UV_fifo_empty  in  1 each  FWFT FIFO empty
Y0_fifo_dout / Y1_fifo_dout / UV_fifo_dout  in  1024 each  FWFT head word
Y0_fifo_rd / Y1_fifo_rd / UV_fifo_rd  out  1 each  pop strobe
mb_valid  out  1  beat valid
mb_ready  in  1  beat accept
mb_data  out  128  beat payload
mb_sop / mb_eop  out  1  first (beat 0) / last (beat 23) beat of MB
mb_is_chroma  out  1  beats 16..23
mb_x / mb_y  out  6  MB coordinates
mb_last  out  1  beat belongs to the final MB of the frame
busy  out  1  frame in progress
done  out  1  one-cycle pulse after final eop handshake

Behaviour:
- Reset: all outputs 0; state IDLE; buffer contents don't-care, but mb_data is 0 while mb_valid=0.
- start_pulse: mb_w=(w1+15)>>4, mb_h=(h1+15)>>4 (11-bit intermediate). Clear x,y,beat. Enter WAIT and set busy. If mb_w==0 or mb_h==0: go to DONE without popping.
- FIFO words: byte k = bits [8k+7:8k].
  - Y0: luma rows 0-7. Y1: luma rows 8-15. Byte 16r+c = row r, column c.
  - UV: bytes 0-63 = U 8x8, bytes 64-127 = V 8x8, row-major.
- Beat b, 0..15: luma row b, taken from Y0 bytes 16b..16b+15 (b<8) or Y1 bytes 16(b-8).. (b>=8). Byte 0 goes to mb_data[7:0].
- Beat 16+j: U row j (UV bytes 8j..8j+7) in [63:0]; V row j (UV bytes 64+8j..) in [127:64].
- States:
  - IDLE: wait for start_pulse.
  - WAIT: when all three FIFOs are non-empty, pulse all three rd for one cycle, capture all three douts into a 3072-bit buffer, beat=0, go to SEND. Never pop a subset.
  - SEND: mb_valid=1. Each mb_valid&&mb_ready advances beat.
    - On the beat-23 handshake, advance x. On x==mb_w-1, wrap x to 0 and increment y.
    - If the MB was last: go to DONE.
    - Else if all FIFOs are non-empty in that same cycle: pop and capture, stay in SEND with beat=0 (zero-bubble MB back-to-back).
    - Else go to WAIT.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Latency: first beat is valid one cycle after the pop cycle.
- mb_valid, beat, x, y are registered. mb_data is muxed from the buffer by the registered beat, with no combinational path from FIFO inputs.
- Hold rule: while mb_valid && !mb_ready, mb_data and all sideband outputs hold stable.
- mb_last = (x==mb_w-1)&&(y==mb_h-1) across all 24 beats.
- start_pulse in any state (including mid-SEND) aborts: mb_valid=0 next cycle, buffer discarded, restart per new w1/h1. start_pulse has priority over handshake in the same cycle.
- Partial-edge MBs are emitted as full 24 beats; the upstream stage supplies padding.

Optional Feature:
Macro MB_ASSEMBLER_PERF_EN.
- Defined: adds outputs stall_in_cnt[31:0] and stall_out_cnt[31:0], both cleared on start_pulse and saturating at 0xFFFFFFFF.
  - stall_in_cnt: cycles in WAIT with any FIFO empty.
  - stall_out_cnt: cycles with mb_valid && !mb_ready.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package mb_pkg holds:
  - state encoding (IDLE/WAIT/SEND/DONE);
  - LUMA_BEATS=16, CHROMA_BEATS=8, MB_BEATS=24;
  - MB_PIX=16, BYTES_PER_WORD=128, UV_V_OFFSET=64.
- One sub-module, mb_beat_select: combinational selection of the 128-bit beat from the 3072-bit buffer by 5-bit beat index.

Test Plan:
1. w1=16, h1=16; each FIFO holds one word with byte k=k; mb_ready=1 -> exactly one rd pulse per FIFO; 24 consecutive beats.
   - beat 1 = bytes 16..31 of Y0.
   - beat 16 [63:0] = UV bytes 0..7, [127:64] = bytes 64..71.
   - sop at beat 0; eop and mb_last at beat 23; done pulses the next cycle.
2. w1=33, h1=17, FIFOs prefilled -> 6 MBs in order (0,0)(1,0)(2,0)(0,1)(1,1)(2,1); 144 contiguous valid cycles with no inter-MB bubble; mb_last only on the 6th MB.
3. mb_ready toggling 1010..., then held low for 5 cycles at beat 7 -> mb_data, sop/eop and mb_x/mb_y stable while stalled; no beat dropped or duplicated.
4. Y0 and Y1 non-empty, UV empty for 20 cycles -> no rd asserted on any FIFO and mb_valid=0; pops occur on the cycle UV becomes non-empty.
5. start_pulse at beat 10 of MB (1,0) with w1=16, h1=16 -> mb_valid=0 next cycle; restart emits one MB at (0,0) and done pulses once.
6. w1=0, h1=64 -> done one cycle after the DONE transition, no rd, no mb_valid; with PERF_EN, verify stall_in_cnt counts during scenario 4 (=20) and stall_out_cnt=5 for scenario 3's hold.
